// File: rtl/counter_pkg.sv
// Shared constants for the modulo-N counter family.
//   MODE_WRAP / MODE_SAT : values for the SATURATE parameter
//   DIR_UP / DIR_DOWN    : levels of the UP input
package counter_pkg;

    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage : counter_pkg

// File: rtl/prescaler_tick.sv
// Enable prescaler: emits one tick per PRESCALE enabled cycles.
//   clk    in  system clock
//   Reset  in  synchronous active-high reset
//   EN     in  advance enable; EN=0 freezes the phase
//   CLR    in  synchronous phase clear
//   tick   out comb, high on the enabled cycle that completes a period
module prescaler_tick #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic Reset,
    input  logic EN,
    input  logic CLR,
    output logic tick
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;
    logic          at_last;

    // With PRESCALE=1 LAST is 0, so the phase never leaves 0 and tick == EN.
    assign at_last = (cnt_q == LAST);
    assign tick    = EN && at_last;

    // Phase next-state
    always_comb begin
        cnt_d = cnt_q;
        if (CLR) begin
            cnt_d = '0;
        end else if (EN) begin
            cnt_d = at_last ? '0 : cnt_q + PW'(1);
        end
    end

    // Phase register
    always_ff @(posedge clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : prescaler_tick

// File: rtl/counter_nbits_mod.sv
// Parametrised modulo-N up/down counter with load, wrap/saturate mode,
// enable prescaler, registered OV/UF pulses and a sticky OV_flag.
//   clk         in   system clock
//   Reset       in   synchronous active-high reset (highest priority)
//   EN          in   count enable, feeds the prescaler
//   CLR         in   synchronous clear of count, prescaler and OV_flag
//   LOAD        in   synchronous parallel load (clamped to MODULUS-1)
//   load_value  in   value for LOAD
//   UP          in   1 = count up, 0 = count down
//   OV_ack      in   clears OV_flag (a same-cycle new event wins)
//   counter     out  current count
//   OV          out  one-cycle pulse after a tick taken at MODULUS-1 going up
//   UF          out  one-cycle pulse after a tick taken at 0 going down
//   TC          out  comb terminal count for the current direction
//   OV_flag     out  sticky OR of OV and UF
module counter_nbits_mod
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MODULUS  = 10,
    parameter int unsigned     SATURATE = MODE_WRAP,
    parameter int unsigned     PRESCALE = 1
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             EN,
    input  logic             CLR,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] load_value,
    input  logic             UP,
    input  logic             OV_ack,
    output logic [WIDTH-1:0] counter,
    output logic             OV,
    output logic             UF,
    output logic             TC,
    output logic             OV_flag
);

    // Limit held one bit wider so MODULUS = 2**WIDTH needs no special case.
    localparam int unsigned    XW   = WIDTH + 1;
    localparam logic [WIDTH:0] LAST = XW'(MODULUS - 64'd1);
    localparam bit             SAT  = (SATURATE == MODE_SAT);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ov_q, ov_d;
    logic             uf_q, uf_d;
    logic             flag_q, flag_d;
    logic [WIDTH:0]   cnt_x;
    logic [WIDTH:0]   load_x;
    logic             at_max;
    logic             at_zero;
    logic             tick;

    prescaler_tick #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .Reset (Reset),
        .EN    (EN),
        .CLR   (CLR | LOAD),
        .tick  (tick)
    );

    assign cnt_x   = {1'b0, cnt_q};
    assign load_x  = {1'b0, load_value};
    assign at_max  = (cnt_x == LAST);
    assign at_zero = (cnt_x == '0);

    assign TC = (UP == DIR_DOWN) ? at_zero : at_max;

    // Count step, limit pulses and sticky flag next-state
    always_comb begin
        cnt_d  = cnt_q;
        ov_d   = 1'b0;
        uf_d   = 1'b0;
        flag_d = flag_q & ~OV_ack;
        if (CLR) begin
            cnt_d  = '0;
            flag_d = 1'b0;
        end else if (LOAD) begin
            cnt_d = (load_x > LAST) ? WIDTH'(LAST) : load_value;
        end else if (tick) begin
            if (UP == DIR_UP) begin
                ov_d = at_max;
                if (!at_max) begin
                    cnt_d = WIDTH'(cnt_x + XW'(1));
                end else if (!SAT) begin
                    cnt_d = '0;
                end
            end else begin
                uf_d = at_zero;
                if (!at_zero) begin
                    cnt_d = WIDTH'(cnt_x - XW'(1));
                end else if (!SAT) begin
                    cnt_d = WIDTH'(LAST);
                end
            end
            // A new limit event overrides a simultaneous acknowledge.
            if (ov_d || uf_d) begin
                flag_d = 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (Reset) begin
            cnt_q  <= '0;
            ov_q   <= 1'b0;
            uf_q   <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ov_q   <= ov_d;
            uf_q   <= uf_d;
            flag_q <= flag_d;
        end
    end

    assign counter = cnt_q;
    assign OV      = ov_q;
    assign UF      = uf_q;
    assign OV_flag = flag_q;

endmodule : counter_nbits_mod

// File: tb/tb_counter_nbits_mod.sv
// Bench for counter_nbits_mod: four configurations share one stimulus stream
//   0: MODULUS=10 wrap      1: MODULUS=10 saturate
//   2: MODULUS=10 PRESCALE=3 3: MODULUS=16 wrap
// An arithmetic model per instance is compared every cycle; literal checks pin it.
module tb_counter_nbits_mod;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       Reset, EN, CLR, LOAD, UP, OV_ack;
    logic [3:0] load_value;
    logic [3:0] cnt [N];
    logic       ov  [N];
    logic       uf  [N];
    logic       tc  [N];
    logic       fl  [N];

    int n_pass  = 0;
    int n_total = 0;

    int m_c [N];
    int m_p [N];
    bit m_ov[N];
    bit m_uf[N];
    bit m_f [N];
    bit model_ok = 1'b0;

    always #5 clk = ~clk;

    counter_nbits_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(1)) u0 (
        .clk(clk), .Reset(Reset), .EN(EN), .CLR(CLR), .LOAD(LOAD), .load_value(load_value),
        .UP(UP), .OV_ack(OV_ack), .counter(cnt[0]), .OV(ov[0]), .UF(uf[0]), .TC(tc[0]),
        .OV_flag(fl[0]));
    counter_nbits_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .PRESCALE(1)) u1 (
        .clk(clk), .Reset(Reset), .EN(EN), .CLR(CLR), .LOAD(LOAD), .load_value(load_value),
        .UP(UP), .OV_ack(OV_ack), .counter(cnt[1]), .OV(ov[1]), .UF(uf[1]), .TC(tc[1]),
        .OV_flag(fl[1]));
    counter_nbits_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(3)) u2 (
        .clk(clk), .Reset(Reset), .EN(EN), .CLR(CLR), .LOAD(LOAD), .load_value(load_value),
        .UP(UP), .OV_ack(OV_ack), .counter(cnt[2]), .OV(ov[2]), .UF(uf[2]), .TC(tc[2]),
        .OV_flag(fl[2]));
    counter_nbits_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .PRESCALE(1)) u3 (
        .clk(clk), .Reset(Reset), .EN(EN), .CLR(CLR), .LOAD(LOAD), .load_value(load_value),
        .UP(UP), .OV_ack(OV_ack), .counter(cnt[3]), .OV(ov[3]), .UF(uf[3]), .TC(tc[3]),
        .OV_flag(fl[3]));

    function automatic int mod_of(input int k);
        return (k == 3) ? 16 : 10;
    endfunction

    function automatic bit sat_of(input int k);
        return (k == 1);
    endfunction

    function automatic int pre_of(input int k);
        return (k == 2) ? 3 : 1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: rules applied to integer count and enabled-cycle phase
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            int  m, pr, c, p;
            bit  t, o, u, f;
            m  = mod_of(k);
            pr = pre_of(k);
            c  = m_c[k];
            p  = m_p[k];
            f  = m_f[k];
            o  = 1'b0;
            u  = 1'b0;
            if (Reset) begin
                c = 0; p = 0; f = 1'b0;
            end else if (CLR) begin
                c = 0; p = 0; f = 1'b0;
            end else if (LOAD) begin
                c = (int'(load_value) >= m) ? m - 1 : int'(load_value);
                p = 0;
                f = f && !OV_ack;
            end else begin
                t = EN && (p == pr - 1);
                if (EN) p = (p + 1) % pr;
                if (t && UP) begin
                    o = (c == m - 1);
                    c = sat_of(k) ? ((c + 1 > m - 1) ? m - 1 : c + 1) : (c + 1) % m;
                end else if (t) begin
                    u = (c == 0);
                    c = sat_of(k) ? ((c == 0) ? 0 : c - 1) : (c + m - 1) % m;
                end
                f = o || u || (f && !OV_ack);
            end
            m_c[k]  <= c;
            m_p[k]  <= p;
            m_ov[k] <= o;
            m_uf[k] <= u;
            m_f[k]  <= f;
        end
        if (Reset) model_ok <= 1'b1;
    end

    // Every-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        if (model_ok) begin
            for (int k = 0; k < N; k++) begin
                int m;
                m = mod_of(k);
                check($sformatf("i%0d.counter", k), int'(cnt[k]), m_c[k]);
                check($sformatf("i%0d.OV", k), int'(ov[k]), int'(m_ov[k]));
                check($sformatf("i%0d.UF", k), int'(uf[k]), int'(m_uf[k]));
                check($sformatf("i%0d.TC", k), int'(tc[k]),
                      int'(UP ? (m_c[k] == m - 1) : (m_c[k] == 0)));
                check($sformatf("i%0d.OV_flag", k), int'(fl[k]), int'(m_f[k]));
            end
        end
    end

    task automatic step(input bit rst, input bit en, input bit up, input bit clr,
                        input bit ld, input logic [3:0] lv, input bit ack);
        Reset = rst; EN = en; UP = up; CLR = clr; LOAD = ld; load_value = lv; OV_ack = ack;
        @(posedge clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1; EN = 1'b0; UP = 1'b1; CLR = 1'b0; LOAD = 1'b0;
        load_value = 4'd0; OV_ack = 1'b0;
        step(1, 0, 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0);
        check("lit.reset_cnt", int'(cnt[0]), 0);
        check("lit.reset_flag", int'(fl[0]), 0);

        // Count to 7, then reset held three cycles with EN still high
        for (int i = 0; i < 7; i++) step(0, 1, 1, 0, 0, 0, 0);
        check("lit.count7", int'(cnt[0]), 7);
        check("lit.pre_count7", int'(cnt[2]), 2);
        step(1, 1, 1, 0, 0, 0, 0);
        check("lit.midreset_cnt", int'(cnt[0]), 0);
        check("lit.midreset_ov", int'(ov[0]), 0);
        check("lit.midreset_pre", int'(cnt[2]), 0);
        step(1, 1, 1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0, 0);

        // Ten up ticks: wrap with OV, saturate holds with OV
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 0, 0, 0);
        check("lit.wrap_cnt", int'(cnt[0]), 0);
        check("lit.wrap_ov", int'(ov[0]), 1);
        check("lit.wrap_flag", int'(fl[0]), 1);
        check("lit.sat_cnt", int'(cnt[1]), 9);
        check("lit.sat_ov", int'(ov[1]), 1);
        check("lit.m16_cnt", int'(cnt[3]), 10);
        step(0, 0, 1, 0, 0, 0, 0);
        check("lit.ov_one_cycle", int'(ov[0]), 0);
        check("lit.flag_sticky", int'(fl[0]), 1);
        step(0, 0, 1, 0, 0, 0, 1);
        check("lit.flag_ack", int'(fl[0]), 0);

        // Down from 0: wrap to 9 vs saturate at 0 pulsing every tick
        step(0, 0, 1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        check("lit.down_wrap_cnt", int'(cnt[0]), 9);
        check("lit.down_wrap_uf", int'(uf[0]), 1);
        check("lit.down_sat_cnt", int'(cnt[1]), 0);
        check("lit.down_sat_uf1", int'(uf[1]), 1);
        step(0, 1, 0, 0, 0, 0, 0);
        check("lit.down_sat_uf2", int'(uf[1]), 1);
        check("lit.down_wrap_8", int'(cnt[0]), 8);

        // Load clamp, then LOAD with CLR
        step(0, 1, 1, 0, 1, 4'd12, 0);
        check("lit.load_clamp", int'(cnt[0]), 9);
        check("lit.load_m16", int'(cnt[3]), 12);
        step(0, 1, 1, 1, 1, 4'd12, 0);
        check("lit.load_clr", int'(cnt[0]), 0);

        // Prescale 3 with EN pattern 1,1,0,1
        step(0, 1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        check("lit.pre_hold", int'(cnt[2]), 0);
        step(0, 1, 1, 0, 0, 0, 0);
        check("lit.pre_step", int'(cnt[2]), 1);

        // MODULUS=16 rollover, with acknowledge colliding with a new OV
        step(0, 0, 1, 0, 1, 4'd15, 1);
        check("lit.m16_load15", int'(cnt[3]), 15);
        step(0, 1, 1, 0, 0, 0, 1);
        check("lit.m16_roll", int'(cnt[3]), 0);
        check("lit.m16_ov", int'(ov[3]), 1);
        check("lit.m16_ack_vs_set", int'(fl[3]), 1);

        // Mixed directed pattern
        for (int i = 0; i < 80; i++) begin
            step(0, (i % 5) != 0, ((i / 20) % 2) == 0, i == 50, (i % 23) == 11,
                 4'(i % 16), (i % 7) == 0);
        end
        step(0, 0, 1, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_counter_nbits_mod
